// File: rtl/lbp_engine.sv
// lbp_engine: 3x3 local-binary-pattern engine over a row-major gray frame.
// Pixels are read over a ready-qualified request port. The window slides
// along a row so only the new right-hand column is fetched per step.
// One 8-bit code per interior pixel is written to a back-pressured port.
// Optional feature: define LBP_BORDER_WRITE_EN to also emit zero codes for
// border pixels, giving one output per frame pixel in raster order.
module lbp_engine #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int DW    = 8,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          finish,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic          gray_ready,
    input  logic [DW-1:0] gray_data,
    output logic          lbp_valid,
    input  logic          lbp_ready,
    output logic [AW-1:0] lbp_addr,
    output logic [7:0]    lbp_data
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_IN_LAST = CW'(IMG_W - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_EMIT,
        S_SHIFT,
        S_DONE
`ifdef LBP_BORDER_WRITE_EN
        , S_BORDER
`endif
    } state_t;

`ifdef LBP_BORDER_WRITE_EN
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] START_ROW = '0;
    localparam logic [CW-1:0] START_COL = '0;
    localparam state_t        S_START   = S_BORDER;
`else
    localparam logic [RW-1:0] ROW_IN_LAST = RW'(IMG_H - 2);
    localparam logic [RW-1:0] START_ROW   = RW'(1);
    localparam logic [CW-1:0] START_COL   = CW'(1);
    localparam state_t        S_START     = S_FILL;
`endif

    state_t                     state;
    state_t                     state_nx;
    logic [RW-1:0]              row;
    logic [CW-1:0]              col;
    logic [1:0]                 rd_r;
    logic [1:0]                 rd_c;
    logic [2:0][2:0][DW-1:0]    win;
    logic [2:0][2:0][DW-1:0]    win_nx;
    logic                       last_rd;

`ifdef LBP_BORDER_WRITE_EN
    logic row_inner;
    assign row_inner = (row != '0) && (row != ROW_LAST);
`endif

    // Neighbour >= centre, bit order TL,T,TR,L,R,BL,B,BR from b0 upwards.
    function automatic logic [7:0] lbp_code(input logic [2:0][2:0][DW-1:0] x);
        logic [DW-1:0] c;
        c = x[1][1];
        return {x[2][2] >= c, x[2][1] >= c, x[2][0] >= c, x[1][2] >= c,
                x[1][0] >= c, x[0][2] >= c, x[0][1] >= c, x[0][0] >= c};
    endfunction

    assign last_rd = (rd_r == 2'd2) && (rd_c == 2'd2);

    // Window with the pixel of the current transfer merged in, so the code
    // can be registered on the same edge as the last read.
    always_comb begin
        win_nx             = win;
        win_nx[rd_r][rd_c] = gray_data;
    end

    // Request and result addresses derived from the position registers.
    always_comb begin
        gray_addr = '0;
        lbp_addr  = '0;
        if (gray_req) begin
            gray_addr = (AW'(row) + AW'(rd_r) - AW'(1)) * AW'(IMG_W)
                      + AW'(col) + AW'(rd_c) - AW'(1);
        end
        if (lbp_valid) begin
            lbp_addr = AW'(row) * AW'(IMG_W) + AW'(col);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        finish    = 1'b0;
        gray_req  = 1'b0;
        lbp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_START;
            end
            S_FILL, S_SHIFT: begin
                busy     = 1'b1;
                gray_req = 1'b1;
                if (gray_ready && last_rd) state_nx = S_EMIT;
            end
            S_EMIT: begin
                busy      = 1'b1;
                lbp_valid = 1'b1;
                if (lbp_ready) begin
                    if (col < COL_IN_LAST)      state_nx = S_SHIFT;
`ifdef LBP_BORDER_WRITE_EN
                    else                        state_nx = S_BORDER;
`else
                    else if (row < ROW_IN_LAST) state_nx = S_FILL;
                    else                        state_nx = S_DONE;
`endif
                end
            end
`ifdef LBP_BORDER_WRITE_EN
            S_BORDER: begin
                busy      = 1'b1;
                lbp_valid = 1'b1;
                if (lbp_ready) begin
                    if (col < COL_LAST)
                        state_nx = (row_inner && col == '0) ? S_FILL : S_BORDER;
                    else if (row < ROW_LAST)
                        state_nx = S_BORDER;
                    else
                        state_nx = S_DONE;
                end
            end
`endif
            S_DONE: begin
                finish = 1'b1;
                if (start) state_nx = S_START;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Position counters, read sequencing, window and registered code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row      <= '0;
            col      <= '0;
            rd_r     <= '0;
            rd_c     <= '0;
            win      <= '0;
            lbp_data <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        row      <= START_ROW;
                        col      <= START_COL;
                        rd_r     <= '0;
                        rd_c     <= '0;
                        lbp_data <= '0;
                    end
                end
                S_FILL, S_SHIFT: begin
                    if (gray_ready) begin
                        win <= win_nx;
                        if (last_rd) begin
                            lbp_data <= lbp_code(win_nx);
                        end else if (rd_r == 2'd2) begin
                            rd_r <= '0;
                            rd_c <= rd_c + 2'd1;
                        end else begin
                            rd_r <= rd_r + 2'd1;
                        end
                    end
                end
                S_EMIT: begin
                    if (lbp_ready) begin
                        rd_r <= '0;
                        if (col < COL_IN_LAST) begin
                            // Slide left; only the right column is refetched.
                            col  <= col + CW'(1);
                            rd_c <= 2'd2;
                            for (int unsigned r = 0; r < 3; r++) begin
                                win[r][0] <= win[r][1];
                                win[r][1] <= win[r][2];
                            end
                        end
`ifdef LBP_BORDER_WRITE_EN
                        else begin
                            col      <= col + CW'(1);
                            lbp_data <= '0;
                        end
`else
                        else if (row < ROW_IN_LAST) begin
                            row  <= row + RW'(1);
                            col  <= CW'(1);
                            rd_c <= '0;
                        end
`endif
                    end
                end
`ifdef LBP_BORDER_WRITE_EN
                S_BORDER: begin
                    if (lbp_ready) begin
                        if (col < COL_LAST) begin
                            col  <= col + CW'(1);
                            rd_r <= '0;
                            rd_c <= '0;
                        end else if (row < ROW_LAST) begin
                            row <= row + RW'(1);
                            col <= '0;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_engine.sv
// Self-checking bench for lbp_engine: a 3x3 directed frame and a 16x16
// engine driven with random frames, random stalls, a flat frame and a
// mid-frame reset, all compared against a pixel-level LBP reference.
module tb_lbp_engine;

    localparam int MW  = 16;
    localparam int MH  = 16;
    localparam int MAW = 8;
`ifdef LBP_BORDER_WRITE_EN
    localparam int   FIRST_ADDR      = 0;
    localparam int   S_COUNT         = 9;
    localparam int   S_IDX           = 4;
    localparam logic REQ_AFTER_START = 1'b0;
`else
    localparam int   FIRST_ADDR      = MW + 1;
    localparam int   S_COUNT         = 1;
    localparam int   S_IDX           = 0;
    localparam logic REQ_AFTER_START = 1'b1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, start, busy, finish, gray_req, gray_ready;
    logic           lbp_valid, lbp_ready;
    logic [MAW-1:0] gray_addr, lbp_addr;
    logic [7:0]     gray_data, lbp_data;
    logic [7:0]     img [MW*MH];
    assign gray_data = img[gray_addr];

    logic           s_start, s_busy, s_finish, s_gray_req, s_gray_ready;
    logic           s_lbp_valid, s_lbp_ready;
    logic [3:0]     s_gray_addr, s_lbp_addr;
    logic [7:0]     s_gray_data, s_lbp_data;
    logic [7:0]     img3 [16];
    assign s_gray_data = img3[s_gray_addr];

    lbp_engine #(.IMG_W(MW), .IMG_H(MH), .DW(8), .AW(MAW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .finish(finish),
        .gray_req(gray_req), .gray_addr(gray_addr), .gray_ready(gray_ready),
        .gray_data(gray_data), .lbp_valid(lbp_valid), .lbp_ready(lbp_ready),
        .lbp_addr(lbp_addr), .lbp_data(lbp_data)
    );

    lbp_engine #(.IMG_W(3), .IMG_H(3), .DW(8), .AW(4)) dut3 (
        .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .finish(s_finish),
        .gray_req(s_gray_req), .gray_addr(s_gray_addr), .gray_ready(s_gray_ready),
        .gray_data(s_gray_data), .lbp_valid(s_lbp_valid), .lbp_ready(s_lbp_ready),
        .lbp_addr(s_lbp_addr), .lbp_data(s_lbp_data)
    );

    int checks = 0;
    int errors = 0;
    int exp_addr[$], exp_data[$], got_addr[$], got_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference code for the pixel at (r,c), straight from the neighbour rule.
    function automatic int ref_code(input int r, input int c);
        int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        int code = 0;
        for (int i = 0; i < 8; i++)
            if (img[(r + dr[i]) * MW + c + dc[i]] >= img[r * MW + c]) code += (1 << i);
        return code;
    endfunction

    function automatic void build_expected();
        exp_addr.delete();
        exp_data.delete();
        for (int r = 0; r < MH; r++)
            for (int c = 0; c < MW; c++) begin
                if (r > 0 && r < MH - 1 && c > 0 && c < MW - 1) begin
                    exp_addr.push_back(r * MW + c);
                    exp_data.push_back(ref_code(r, c));
                end
`ifdef LBP_BORDER_WRITE_EN
                else begin
                    exp_addr.push_back(r * MW + c);
                    exp_data.push_back(0);
                end
`endif
            end
    endfunction

    task automatic fill_random(input bit narrow);
        for (int i = 0; i < MW * MH; i++)
            img[i] = narrow ? 8'($urandom_range(0, 7) << 5) : 8'($urandom_range(0, 255));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "/gray_req"},  32'(gray_req),  0);
        chk({tag, "/gray_addr"}, 32'(gray_addr), 0);
        chk({tag, "/lbp_valid"}, 32'(lbp_valid), 0);
        chk({tag, "/lbp_addr"},  32'(lbp_addr),  0);
        chk({tag, "/lbp_data"},  32'(lbp_data),  0);
        chk({tag, "/busy"},      32'(busy),      0);
        chk({tag, "/finish"},    32'(finish),    0);
    endtask

    // Runs one frame on the 16x16 engine; called and returns on a falling edge.
    task automatic run_frame(input bit stall_g, input bit stall_l, input string tag);
        int first_req = -1;
        int done_cyc  = -1;
        int ovl       = 0;
        int unstable  = 0;
        int n;
        bit g_hold = 1'b0;
        bit l_hold = 1'b0;
        logic [MAW-1:0] g_addr_h = '0;
        logic [MAW-1:0] l_addr_h = '0;
        logic [7:0]     l_data_h = '0;
        build_expected();
        got_addr.delete();
        got_data.delete();
        gray_ready = 1'b1;
        lbp_ready  = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/busy_after_start"},   32'(busy),     1);
        chk({tag, "/finish_after_start"}, 32'(finish),   0);
        chk({tag, "/req_after_start"},    32'(gray_req), 32'(REQ_AFTER_START));
        for (int cyc = 0; cyc < 20000; cyc++) begin
            gray_ready = (stall_g && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            lbp_ready  = (stall_l && $urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
            if (g_hold && (!gray_req || gray_addr !== g_addr_h)) unstable++;
            if (l_hold && (!lbp_valid || lbp_addr !== l_addr_h || lbp_data !== l_data_h)) unstable++;
            if (gray_req && lbp_valid) ovl++;
            if (gray_req && first_req < 0) first_req = cyc;
            if (lbp_valid && lbp_ready) begin
                got_addr.push_back(int'(lbp_addr));
                got_data.push_back(int'(lbp_data));
            end
            g_hold   = gray_req && !gray_ready;
            g_addr_h = gray_addr;
            l_hold   = lbp_valid && !lbp_ready;
            l_addr_h = lbp_addr;
            l_data_h = lbp_data;
            if (finish) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "/reached_done"}, 32'(done_cyc >= 0), 1);
        chk({tag, "/count"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s/addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
            chk($sformatf("%s/data%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
        end
        chk({tag, "/req_valid_overlap"}, 32'(ovl), 0);
        chk({tag, "/stall_stability"},   32'(unstable), 0);
        chk({tag, "/busy_in_done"},      32'(busy), 0);
        chk({tag, "/finish_in_done"},    32'(finish), 1);
`ifndef LBP_BORDER_WRITE_EN
        if (!stall_g && !stall_l)
            chk({tag, "/req_to_done_cycles"}, 32'(done_cyc - first_req),
                32'((MH - 2) * (10 + (MW - 3) * 4)));
`endif
    endtask

    initial begin
        int s_addr[$], s_data[$];
        reset        = 1'b0;
        start        = 1'b0;
        gray_ready   = 1'b1;
        lbp_ready    = 1'b1;
        s_start      = 1'b0;
        s_gray_ready = 1'b1;
        s_lbp_ready  = 1'b1;
        for (int i = 0; i < 16; i++) img3[i] = 8'h00;
        img3[0] = 8'd10; img3[1] = 8'd60; img3[2] = 8'd50;
        img3[3] = 8'd40; img3[4] = 8'd50; img3[5] = 8'd70;
        img3[6] = 8'd20; img3[7] = 8'd50; img3[8] = 8'd90;
        for (int i = 0; i < MW * MH; i++) img[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk_quiet("reset");
        chk("reset3/busy",   32'(s_busy),   0);
        chk("reset3/finish", 32'(s_finish), 0);
        reset = 1'b1;
        @(negedge clk);

        // Directed 3x3 frame with a known code.
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (s_lbp_valid && s_lbp_ready) begin
                s_addr.push_back(int'(s_lbp_addr));
                s_data.push_back(int'(s_lbp_data));
            end
            if (s_finish) break;
            @(negedge clk);
        end
        chk("3x3/count",  32'(s_addr.size()), 32'(S_COUNT));
        chk("3x3/finish", 32'(s_finish), 1);
        if (s_addr.size() > S_IDX) begin
            chk("3x3/addr", 32'(s_addr[S_IDX]), 4);
            chk("3x3/data", 32'(s_data[S_IDX]), 32'h0D6);
        end

        // Random frame with many ties, free-flowing then heavily stalled.
        fill_random(1'b1);
        run_frame(1'b0, 1'b0, "rand");
        run_frame(1'b1, 1'b1, "stall");

        // Flat frame: equality sets every bit.
        for (int i = 0; i < MW * MH; i++) img[i] = 8'h80;
        run_frame(1'b0, 1'b0, "flat");
`ifndef LBP_BORDER_WRITE_EN
        if (got_data.size() > 0) chk("flat/first_code", 32'(got_data[0]), 32'hFF);
`endif

        // Reset in the middle of row 3, then a fresh frame.
        fill_random(1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (130) @(negedge clk);
        chk("midframe/busy_before_reset", 32'(busy), 1);
        reset = 1'b0;
        #1;
        chk_quiet("reset_async");
        @(negedge clk);
        chk_quiet("reset_held");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("after_reset/busy",     32'(busy), 0);
        chk("after_reset/gray_req", 32'(gray_req), 0);
        chk("after_reset/valid",    32'(lbp_valid), 0);
        fill_random(1'b0);
        run_frame(1'b0, 1'b0, "restart");
        if (got_addr.size() > 0) chk("restart/first_addr", 32'(got_addr[0]), 32'(FIRST_ADDR));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
